// File: rtl/leve1_div_seq_if.sv
// Request/response bundle between the EX/WB pipeline (master) and the
// leve1_div_seq iterative divider (slave).
`ifndef XLEN
`define XLEN 64
`endif

// Handshake: a request transfers on a CLK edge where REQ_VALID & REQ_READY are
// both high; a response transfers on an edge where RSP_VALID & RSP_READY are
// both high. A response stays valid and unchanged until it transfers, and KILL
// discards whatever is in flight without producing a response.
interface leve1_div_seq_if #(parameter int W = `XLEN);
   logic         REQ_VALID;
   logic         REQ_READY;
   logic [1:0]   REQ_OP;
   logic         REQ_WORD;
   logic [W-1:0] REQ_RS1;
   logic [W-1:0] REQ_RS2;
   logic         KILL;
   logic         BUSY;
   logic         RSP_VALID;
   logic         RSP_READY;
   logic [W-1:0] RSP_DATA;
   logic [2:0]   DBG_STATE;

   modport master (
      output REQ_VALID, REQ_OP, REQ_WORD, REQ_RS1, REQ_RS2, KILL, RSP_READY,
      input  REQ_READY, BUSY, RSP_VALID, RSP_DATA, DBG_STATE
   );

   modport slave (
      input  REQ_VALID, REQ_OP, REQ_WORD, REQ_RS1, REQ_RS2, KILL, RSP_READY,
      output REQ_READY, BUSY, RSP_VALID, RSP_DATA, DBG_STATE
   );
endinterface

// File: rtl/leve1_div_seq.sv
// Iterative restoring divider for DIV/DIVU/REM/REMU and their *W forms.
// Define LEVE_DIV_ZERO_BYPASS_EN to route divide-by-zero/overflow PREP -> FIX.
`ifndef XLEN
`define XLEN 64
`endif

module leve1_div_seq #(
   parameter int W = `XLEN
) (
   input logic              CLK,
   input logic              RST,
   leve1_div_seq_if.slave   bus
);

   localparam int CW = $clog2(W + 1);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      PREP = 3'd1,
      CALC = 3'd2,
      FIX  = 3'd3,
      DONE = 3'd4
   } state_t;

   state_t         state;
   logic [1:0]     op;
   logic           word;
   logic [W-1:0]   rs1;
   logic [W-1:0]   rs2;
   logic [W-1:0]   dividend;
   logic [W-1:0]   d_mag;
   logic [W-1:0]   q;
   logic [W-1:0]   r;
   logic           neg_q;
   logic           neg_r;
   logic           div_zero;
   logic           ovf;
   logic [CW-1:0]  cnt;
   logic           rsp_valid;
   logic [W-1:0]   rsp_data;

   // Operand conditioning, only meaningful while in PREP.
   logic           is_signed;
   logic [W-1:0]   a_ext;
   logic [W-1:0]   b_ext;
   logic [W-1:0]   min_neg;
   logic           a_neg;
   logic           b_neg;
   logic [W-1:0]   a_mag;
   logic [W-1:0]   b_mag;
   logic           zero_c;
   logic           ovf_c;

   always_comb begin
      is_signed = ~op[0];
      a_ext     = rs1;
      b_ext     = rs2;
      min_neg   = {1'b1, {(W-1){1'b0}}};
      if (word) begin
         a_ext   = is_signed ? {{(W-32){rs1[31]}}, rs1[31:0]} : {{(W-32){1'b0}}, rs1[31:0]};
         b_ext   = is_signed ? {{(W-32){rs2[31]}}, rs2[31:0]} : {{(W-32){1'b0}}, rs2[31:0]};
         min_neg = {{(W-31){1'b1}}, {31{1'b0}}};
      end
      a_neg  = is_signed & a_ext[W-1];
      b_neg  = is_signed & b_ext[W-1];
      a_mag  = a_neg ? (~a_ext + 1'b1) : a_ext;
      b_mag  = b_neg ? (~b_ext + 1'b1) : b_ext;
      zero_c = (b_ext == '0);
      ovf_c  = is_signed & (a_ext == min_neg) & (b_ext == '1);
   end

   // One restoring step: shift the next dividend bit into the partial remainder.
   logic [W:0]     rem_shift;
   logic [W:0]     diff;
   logic           fits;

   always_comb begin
      rem_shift = {r, q[W-1]};
      diff      = rem_shift - {1'b0, d_mag};
      fits      = ~diff[W];
   end

   // Sign fix-up, special-case override and word extension of the result.
   logic [W-1:0]   q_s;
   logic [W-1:0]   r_s;
   logic [W-1:0]   sel;
   logic [W-1:0]   result;

   always_comb begin
      q_s = neg_q ? (~q + 1'b1) : q;
      r_s = neg_r ? (~r + 1'b1) : r;
      sel = op[1] ? r_s : q_s;
      if (div_zero) begin
         sel = op[1] ? dividend : '1;
      end else if (ovf) begin
         sel = op[1] ? '0 : dividend;
      end
      result = word ? {{(W-32){sel[31]}}, sel[31:0]} : sel;
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state     <= IDLE;
         op        <= 2'b00;
         word      <= 1'b0;
         rs1       <= '0;
         rs2       <= '0;
         dividend  <= '0;
         d_mag     <= '0;
         q         <= '0;
         r         <= '0;
         neg_q     <= 1'b0;
         neg_r     <= 1'b0;
         div_zero  <= 1'b0;
         ovf       <= 1'b0;
         cnt       <= '0;
         rsp_valid <= 1'b0;
         rsp_data  <= '0;
      end else if (state != IDLE && bus.KILL) begin
         state     <= IDLE;
         cnt       <= '0;
         rsp_valid <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.REQ_VALID && !bus.KILL) begin
                  op    <= bus.REQ_OP;
                  word  <= bus.REQ_WORD;
                  rs1   <= bus.REQ_RS1;
                  rs2   <= bus.REQ_RS2;
                  state <= PREP;
               end
            end
            PREP: begin
               dividend <= a_ext;
               d_mag    <= b_mag;
               // Word operands sit in the top half so the low half ends up holding the quotient.
               q        <= word ? (a_mag << 32) : a_mag;
               r        <= '0;
               neg_q    <= a_neg ^ b_neg;
               neg_r    <= a_neg;
               div_zero <= zero_c;
               ovf      <= ovf_c;
               cnt      <= word ? CW'(32) : CW'(W);
               state    <= CALC;
`ifdef LEVE_DIV_ZERO_BYPASS_EN
               if (zero_c || ovf_c) begin
                  cnt   <= '0;
                  state <= FIX;
               end
`endif
            end
            CALC: begin
               r   <= fits ? diff[W-1:0] : rem_shift[W-1:0];
               q   <= {q[W-2:0], fits};
               cnt <= cnt - 1'b1;
               if (cnt == CW'(1)) begin
                  state <= FIX;
               end
            end
            FIX: begin
               rsp_data  <= result;
               rsp_valid <= 1'b1;
               state     <= DONE;
            end
            DONE: begin
               if (bus.RSP_READY) begin
                  rsp_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: begin
               rsp_valid <= 1'b0;
               state     <= IDLE;
            end
         endcase
      end
   end

   assign bus.REQ_READY = (state == IDLE) & ~bus.KILL & ~RST;
   assign bus.BUSY      = (state != IDLE);
   assign bus.RSP_VALID = rsp_valid;
   assign bus.RSP_DATA  = rsp_data;
   assign bus.DBG_STATE = state;

   a_valid_only_in_done: assert property (@(posedge CLK) disable iff (RST)
      rsp_valid |-> (state == DONE));

   a_hold_in_done: assert property (@(posedge CLK) disable iff (RST)
      (state == DONE && !bus.RSP_READY && !bus.KILL) |=> (rsp_valid && $stable(rsp_data)));

   a_calc_counter_live: assert property (@(posedge CLK) disable iff (RST)
      (state == CALC) |-> (cnt != '0));

endmodule
